// File: rtl/ofmap_sparse_encoder_pkg.sv
// Shared widths, state type and coordinate lookup tables for the sparse
// output-feature-map encoder.
package ofmap_enc_pkg;

  localparam int WORD_LENGTH        = 8;
  localparam int DOUBLE_WORD_LENGTH = 16;
  localparam int COL_LENGTH         = 8;
  localparam int OUTPUT_COL_SIZE    = 5;
  localparam int OUTPUT_SIZE        = 25;
  localparam int COUNT_WIDTH        = 6;
  localparam int SHIFT_WIDTH        = 4;
  localparam int POS_WIDTH          = $clog2(OUTPUT_SIZE);
  localparam int Q_MAX_INT          = 2 ** (WORD_LENGTH - 1) - 1;

  typedef enum logic {
    IDLE,
    SCAN
  } enc_state_t;

  // Flattened position p = col + row*OUTPUT_COL_SIZE mapped back to coordinates.
  localparam logic [COL_LENGTH-1:0] COL_LUT [OUTPUT_SIZE] = '{
    8'd0, 8'd1, 8'd2, 8'd3, 8'd4,
    8'd0, 8'd1, 8'd2, 8'd3, 8'd4,
    8'd0, 8'd1, 8'd2, 8'd3, 8'd4,
    8'd0, 8'd1, 8'd2, 8'd3, 8'd4,
    8'd0, 8'd1, 8'd2, 8'd3, 8'd4
  };

  localparam logic [COL_LENGTH-1:0] ROW_LUT [OUTPUT_SIZE] = '{
    8'd0, 8'd0, 8'd0, 8'd0, 8'd0,
    8'd1, 8'd1, 8'd1, 8'd1, 8'd1,
    8'd2, 8'd2, 8'd2, 8'd2, 8'd2,
    8'd3, 8'd3, 8'd3, 8'd3, 8'd3,
    8'd4, 8'd4, 8'd4, 8'd4, 8'd4
  };

endpackage

// File: rtl/ofmap_sparse_encoder_if.sv
// Frame input and sparse beat output handshake bundle of the encoder.
interface ofmap_sparse_encoder_if;
  import ofmap_enc_pkg::*;

  logic                                      in_valid;
  logic                                      in_ready;
  logic [OUTPUT_SIZE*DOUBLE_WORD_LENGTH-1:0] data_in;
  logic [SHIFT_WIDTH-1:0]                    quant_shift;
  logic                                      out_valid;
  logic                                      out_ready;
  logic [WORD_LENGTH-1:0]                    out_data;
  logic [COL_LENGTH-1:0]                     out_col;
  logic [COL_LENGTH-1:0]                     out_row;
  logic                                      out_last;
  logic [COUNT_WIDTH-1:0]                    nnz_count;
  logic                                      done;

  // Master is the environment (frame producer and beat consumer).
  modport master (
    output in_valid, data_in, quant_shift, out_ready,
    input  in_ready, out_valid, out_data, out_col, out_row, out_last, nnz_count, done
  );

  modport slave (
    input  in_valid, data_in, quant_shift, out_ready,
    output in_ready, out_valid, out_data, out_col, out_row, out_last, nnz_count, done
  );

endinterface

// File: rtl/ofmap_sparse_encoder_quant_relu_sat.sv
// One combinational lane: ReLU, arithmetic right-shift requantization and
// saturation of an accumulator word down to a non-negative output word.
module quant_relu_sat
  import ofmap_enc_pkg::*;
(
  input  logic signed [DOUBLE_WORD_LENGTH-1:0] value,
  input  logic        [SHIFT_WIDTH-1:0]        shift,
  output logic        [WORD_LENGTH-1:0]        q
);

  localparam logic signed [DOUBLE_WORD_LENGTH-1:0] LIMIT = DOUBLE_WORD_LENGTH'(Q_MAX_INT);

  logic signed [DOUBLE_WORD_LENGTH-1:0] shifted;

  always_comb begin
    shifted = value >>> shift;
    if (value[DOUBLE_WORD_LENGTH-1] || (value == '0)) begin
      q = '0;
    end else if (shifted > LIMIT) begin
      q = LIMIT[WORD_LENGTH-1:0];
    end else begin
      q = shifted[WORD_LENGTH-1:0];
    end
  end

endmodule

// File: rtl/ofmap_sparse_encoder.sv
// Quantizes one accumulated feature map and streams only its nonzero results
// as (value, col, row) beats in ascending position order.
module ofmap_sparse_encoder
  import ofmap_enc_pkg::*;
(
  input logic                   tclk,
  input logic                   rst,
  ofmap_sparse_encoder_if.slave bus
);

  logic [WORD_LENGTH-1:0] lane_q [OUTPUT_SIZE];
  logic [WORD_LENGTH-1:0] q_buf  [OUTPUT_SIZE];
  logic [OUTPUT_SIZE-1:0] lane_mask;
  logic [OUTPUT_SIZE-1:0] mask;
  logic [OUTPUT_SIZE-1:0] next_bit;
  logic [COUNT_WIDTH-1:0] lane_count;
  logic [POS_WIDTH-1:0]   next_p;
  logic                   next_last;
  enc_state_t             state;

  for (genvar g = 0; g < OUTPUT_SIZE; g++) begin : g_lane
    quant_relu_sat u_lane (
      .value (bus.data_in[g*DOUBLE_WORD_LENGTH +: DOUBLE_WORD_LENGTH]),
      .shift (bus.quant_shift),
      .q     (lane_q[g])
    );
    assign lane_mask[g] = |lane_q[g];
  end

  always_comb begin
    lane_count = '0;
    for (int i = 0; i < OUTPUT_SIZE; i++) begin
      lane_count = lane_count + COUNT_WIDTH'(lane_mask[i]);
    end
  end

  // Downward scan so the lowest pending position wins.
  always_comb begin
    next_p = '0;
    for (int i = OUTPUT_SIZE - 1; i >= 0; i--) begin
      if (mask[i]) begin
        next_p = POS_WIDTH'(i);
      end
    end
    next_bit  = OUTPUT_SIZE'(1) << next_p;
    next_last = (mask & ~next_bit) == '0;
  end

  always_ff @(posedge tclk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      mask          <= '0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_col   <= '0;
      bus.out_row   <= '0;
      bus.out_last  <= 1'b0;
      bus.nnz_count <= '0;
      bus.done      <= 1'b0;
      for (int i = 0; i < OUTPUT_SIZE; i++) begin
        q_buf[i] <= '0;
      end
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            for (int i = 0; i < OUTPUT_SIZE; i++) begin
              q_buf[i] <= lane_q[i];
            end
            mask          <= lane_mask;
            bus.nnz_count <= lane_count;
            bus.in_ready  <= 1'b0;
            state         <= SCAN;
          end
        end
        SCAN: begin
          // Output register refills whenever it is empty or being drained.
          if (!bus.out_valid || bus.out_ready) begin
            if (mask != '0) begin
              bus.out_valid <= 1'b1;
              bus.out_data  <= q_buf[next_p];
              bus.out_col   <= COL_LUT[next_p];
              bus.out_row   <= ROW_LUT[next_p];
              bus.out_last  <= next_last;
              mask          <= mask & ~next_bit;
            end else begin
              bus.out_valid <= 1'b0;
              bus.out_last  <= 1'b0;
              bus.in_ready  <= 1'b1;
              bus.done      <= 1'b1;
              state         <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
